// File: rtl/idi_pkg.sv
// idi_pkg: shared widths and the request record for the IDI request queue.
//   IDI_ADDR_W / IDI_DATA_W / IDI_TAG_W : default widths for address, data, tag
//   IDI_DEPTH                            : default FIFO depth
//   idi_req_t                            : {is_write, addr, wdata, tag}, MSB first
package idi_pkg;

  localparam int IDI_ADDR_W = 64;
  localparam int IDI_DATA_W = 32;
  localparam int IDI_TAG_W  = 4;
  localparam int IDI_DEPTH  = 4;

  typedef struct packed {
    logic                  is_write;
    logic [IDI_ADDR_W-1:0] addr;
    logic [IDI_DATA_W-1:0] wdata;
    logic [IDI_TAG_W-1:0]  tag;
  } idi_req_t;

endpackage

// File: rtl/idi_req_queue_if.sv
// idi_req_queue_if: bundles the requester, bridge and response channels of the
// IDI request queue plus its status outputs.
//   req_*  : requester -> queue (req_ready back)
//   idi_*  : queue -> bridge head entry, bridge -> queue read data pulse
//   rsp_*  : queue -> requester read response (rsp_ready back)
//   count, rd_inflight, err_spurious : status
// Modports: slave = the queue itself, master = its environment.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a rising
// edge where valid and ready are both 1; valid never depends on ready in the
// same cycle. idi_rvalid is the exception: a single-cycle pulse with no ready.
interface idi_req_queue_if
  import idi_pkg::*;
#(
  parameter int ADDR_W = IDI_ADDR_W,
  parameter int DATA_W = IDI_DATA_W,
  parameter int TAG_W  = IDI_TAG_W,
  parameter int DEPTH  = IDI_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_is_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic              idi_valid;
  logic              idi_ready;
  logic              idi_is_write;
  logic [ADDR_W-1:0] idi_addr;
  logic [DATA_W-1:0] idi_wdata;
  logic [DATA_W-1:0] idi_rdata;
  logic              idi_rvalid;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [TAG_W-1:0]  rsp_tag;

  logic [CNT_W-1:0]  count;
  logic              rd_inflight;
  logic              err_spurious;

  modport slave (
    input  req_valid, req_is_write, req_addr, req_wdata, req_tag,
    output req_ready,
    output idi_valid, idi_is_write, idi_addr, idi_wdata,
    input  idi_ready, idi_rdata, idi_rvalid,
    output rsp_valid, rsp_rdata, rsp_tag,
    input  rsp_ready,
    output count, rd_inflight, err_spurious
  );

  modport master (
    output req_valid, req_is_write, req_addr, req_wdata, req_tag,
    input  req_ready,
    input  idi_valid, idi_is_write, idi_addr, idi_wdata,
    output idi_ready, idi_rdata, idi_rvalid,
    input  rsp_valid, rsp_rdata, rsp_tag,
    output rsp_ready,
    input  count, rd_inflight, err_spurious
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO, registered pointers, head shown
// combinationally from storage.
//   clk, rst_n : clock, synchronous active-low reset (storage is not reset)
//   push/wdata : write an entry (ignored when full)
//   pop/rdata  : rdata is the head entry; pop removes it (ignored when empty)
//   full, empty, count : occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  // Pointers wrap naturally at DEPTH (power of two); count separates full/empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/idi_req_queue.sv
// idi_req_queue: in-order request buffer in front of the IDI-to-AXI-lite bridge.
// Requests are queued in a FIFO; the head is offered to the bridge. A read may
// only be dispatched when no read is in flight and no response is held, so the
// bridge's one-cycle rvalid pulse always has an empty response register to land
// in. Writes are never held back by read state, but strict ordering means a
// stalled read at the head blocks everything behind it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : idi_req_queue_if slave modport (req_*, idi_*, rsp_*, status)
module idi_req_queue
  import idi_pkg::*;
#(
  parameter int ADDR_W = IDI_ADDR_W,
  parameter int DATA_W = IDI_DATA_W,
  parameter int TAG_W  = IDI_TAG_W,
  parameter int DEPTH  = IDI_DEPTH
) (
  input logic            clk,
  input logic            rst_n,
  idi_req_queue_if.slave bus
);
  // Entry layout matches idi_req_t field order: {is_write, addr, wdata, tag}.
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               head_is_write;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;
  logic [TAG_W-1:0]   head_tag;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;
  logic               head_valid;

  logic               rd_inflight_q;
  logic [TAG_W-1:0]   inflight_tag_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               err_spurious_q;

  assign push_entry = {bus.req_is_write, bus.req_addr, bus.req_wdata, bus.req_tag};
  assign {head_is_write, head_addr, head_wdata, head_tag} = head_entry;

  assign push       = bus.req_valid && !fifo_full;
  // Read dispatch waits until the response path is completely idle.
  assign head_valid = !fifo_empty && (head_is_write || (!rd_inflight_q && !rsp_valid_q));
  assign pop        = head_valid && bus.idi_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read tracking and response register. The gating above keeps rd_inflight and
  // rsp_valid mutually exclusive, so these updates never contend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_inflight_q  <= 1'b0;
      inflight_tag_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_tag_q      <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
      if (pop && !head_is_write) begin
        rd_inflight_q  <= 1'b1;
        inflight_tag_q <= head_tag;
      end
      if (bus.idi_rvalid) begin
        if (rd_inflight_q) begin
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= bus.idi_rdata;
          rsp_tag_q     <= inflight_tag_q;
          rd_inflight_q <= 1'b0;
        end else begin
          // Data with nothing outstanding (e.g. a bridge completing across our
          // reset) is dropped and flagged until the next reset.
          err_spurious_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready    = !fifo_full;
  assign bus.idi_valid    = head_valid;
  assign bus.idi_is_write = head_is_write;
  assign bus.idi_addr     = head_addr;
  assign bus.idi_wdata    = head_wdata;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.count        = fifo_count;
  assign bus.rd_inflight  = rd_inflight_q;
  assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_idi_req_queue.sv
// tb_idi_req_queue: directed test-plan sequences followed by randomized traffic,
// checked by a negedge monitor against a queue-based reference model.
module tb_idi_req_queue;
  import idi_pkg::*;

  localparam int ADDR_W = IDI_ADDR_W;
  localparam int DATA_W = IDI_DATA_W;
  localparam int TAG_W  = IDI_TAG_W;
  localparam int DEPTH  = 4;
  localparam int RSP_W  = TAG_W + DATA_W;

  localparam int S_COUNT = 0, S_REQ_READY = 1, S_IDI_VALID = 2, S_RSP_VALID = 3,
                 S_RSP_TAG = 4, S_RSP_RDATA = 5, S_RD_INFLIGHT = 6, S_ERR = 7,
                 S_EXPQ = 8, S_RSPQ = 9;

  typedef struct {
    int           sig;
    logic [127:0] exp;
    string        name;
  } dir_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idi_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  idi_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  idi_req_t           exp_q[$];   // accepted requests, in dispatch order
  logic [TAG_W-1:0]   tag_q[$];   // tags of dispatched reads awaiting data
  logic [RSP_W-1:0]   rsp_q[$];   // expected {tag, rdata} responses
  dir_t               dir_q[$];   // directed point checks for the next negedge
  bit                 m_inflight = 1'b0;
  bit                 m_rspv = 1'b0;
  bit                 m_err = 1'b0;
  int                 reads_dispatched = 0;
  int                 reads_returned = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(int sig, logic [127:0] v, string name);
    dir_t d;
    d.sig = sig;
    d.exp = v;
    d.name = name;
    dir_q.push_back(d);
  endtask

  task automatic set_req(logic w, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic [TAG_W-1:0] t);
    bus.req_valid    = 1'b1;
    bus.req_is_write = w;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_tag      = t;
  endtask

  task automatic expect_reset_state();
    expect_sig(S_COUNT, 128'(0), "rst_count");
    expect_sig(S_REQ_READY, 128'(1), "rst_req_ready");
    expect_sig(S_IDI_VALID, 128'(0), "rst_idi_valid");
    expect_sig(S_RSP_VALID, 128'(0), "rst_rsp_valid");
    expect_sig(S_RSP_RDATA, 128'(0), "rst_rsp_rdata");
    expect_sig(S_RSP_TAG, 128'(0), "rst_rsp_tag");
    expect_sig(S_RD_INFLIGHT, 128'(0), "rst_rd_inflight");
    expect_sig(S_ERR, 128'(0), "rst_err_spurious");
  endtask

  task automatic pulse_rvalid(logic [DATA_W-1:0] d);
    bus.idi_rvalid = 1'b1;
    bus.idi_rdata  = d;
    tick();
    bus.idi_rvalid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] sig_val(int s);
    case (s)
      S_COUNT:       return 128'(bus.count);
      S_REQ_READY:   return 128'(bus.req_ready);
      S_IDI_VALID:   return 128'(bus.idi_valid);
      S_RSP_VALID:   return 128'(bus.rsp_valid);
      S_RSP_TAG:     return 128'(bus.rsp_tag);
      S_RSP_RDATA:   return 128'(bus.rsp_rdata);
      S_RD_INFLIGHT: return 128'(bus.rd_inflight);
      S_ERR:         return 128'(bus.err_spurious);
      S_EXPQ:        return 128'(exp_q.size());
      S_RSPQ:        return 128'(rsp_q.size());
      default:       return '1;
    endcase
  endfunction

  idi_req_t         mon_e;
  logic [TAG_W-1:0] mon_t;
  dir_t             mon_d;
  bit               exp_valid;
  bit               n_inflight;
  bit               n_rspv;

  always @(negedge clk) begin
    while (dir_q.size() != 0) begin
      mon_d = dir_q.pop_front();
      chk(mon_d.name, sig_val(mon_d.sig), mon_d.exp);
    end
    if (!rst_n) begin
      exp_q.delete();
      tag_q.delete();
      rsp_q.delete();
      m_inflight = 1'b0;
      m_rspv     = 1'b0;
      m_err      = 1'b0;
    end else begin
      // A read may go out only when nothing is outstanding; writes always may.
      exp_valid = (exp_q.size() != 0) && (exp_q[0].is_write || (!m_inflight && !m_rspv));
      chk("count", 128'(bus.count), 128'(exp_q.size()));
      chk("req_ready", 128'(bus.req_ready), 128'(exp_q.size() != DEPTH));
      chk("idi_valid", 128'(bus.idi_valid), 128'(exp_valid));
      chk("rd_inflight", 128'(bus.rd_inflight), 128'(m_inflight));
      chk("rsp_valid", 128'(bus.rsp_valid), 128'(m_rspv));
      chk("err_spurious", 128'(bus.err_spurious), 128'(m_err));
      n_inflight = m_inflight;
      n_rspv     = m_rspv;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got tag %0h data %0h expected no response",
                   bus.rsp_tag, bus.rsp_rdata);
        end else begin
          chk("rsp", 128'({bus.rsp_tag, bus.rsp_rdata}), 128'(rsp_q.pop_front()));
        end
        n_rspv = 1'b0;
      end
      if (bus.idi_valid && bus.idi_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dispatch_unexpected: got addr %0h expected empty queue", bus.idi_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dispatch", 128'({bus.idi_is_write, bus.idi_addr, bus.idi_wdata}),
              128'({mon_e.is_write, mon_e.addr, mon_e.wdata}));
          if (!mon_e.is_write) begin
            n_inflight = 1'b1;
            tag_q.push_back(mon_e.tag);
            reads_dispatched++;
          end
        end
      end
      if (bus.idi_rvalid) begin
        if (m_inflight && tag_q.size() != 0) begin
          mon_t = tag_q.pop_front();
          rsp_q.push_back({mon_t, bus.idi_rdata});
          n_inflight = 1'b0;
          n_rspv     = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        mon_e.is_write = bus.req_is_write;
        mon_e.addr     = bus.req_addr;
        mon_e.wdata    = bus.req_wdata;
        mon_e.tag      = bus.req_tag;
        exp_q.push_back(mon_e);
      end
      m_inflight = n_inflight;
      m_rspv     = n_rspv;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 1'b0; bus.req_is_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_tag = '0;
    bus.idi_ready = 1'b0; bus.idi_rdata = '0; bus.idi_rvalid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    expect_reset_state();
    tick();

    // Write stream: each write visible one cycle after push, drained at once.
    bus.idi_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 64'(16 * (i + 1)), 32'($urandom), TAG_W'(i));
      tick();
      bus.req_valid = 1'b0;
      expect_sig(S_IDI_VALID, 128'(1), "wr_idi_valid");
      expect_sig(S_COUNT, 128'(1), "wr_count_one");
      tick();
      expect_sig(S_COUNT, 128'(0), "wr_count_zero");
      expect_sig(S_RSP_VALID, 128'(0), "wr_no_rsp");
    end

    // Fill to full with the bridge stalled; the fifth offer is refused.
    bus.idi_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b1, 64'h200 + 64'(k), 32'(k), TAG_W'(k));
      if (k == 4) begin
        expect_sig(S_REQ_READY, 128'(0), "full_req_ready");
        expect_sig(S_COUNT, 128'(4), "full_count");
      end
      tick();
    end
    bus.req_valid = 1'b0;
    expect_sig(S_COUNT, 128'(4), "full_no_fifth");
    bus.idi_ready = 1'b1;
    repeat (4) tick();
    expect_sig(S_COUNT, 128'(0), "drain_count");

    // Read round trip, data two cycles after the pop.
    set_req(1'b0, 64'h100, '0, 4'd3);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    pulse_rvalid(32'hDEADBEEF);
    expect_sig(S_RSP_VALID, 128'(1), "rt_rsp_valid");
    expect_sig(S_RSP_TAG, 128'(3), "rt_rsp_tag");
    expect_sig(S_RSP_RDATA, 128'hDEADBEEF, "rt_rsp_rdata");
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    expect_sig(S_RSP_VALID, 128'(0), "rt_rsp_consumed");

    // Back-pressure: second read waits for the held response to be taken.
    set_req(1'b0, 64'h300, '0, 4'd1);
    tick();
    set_req(1'b0, 64'h304, '0, 4'd2);
    tick();
    bus.req_valid = 1'b0;
    tick();
    pulse_rvalid(32'($urandom));
    expect_sig(S_RSP_VALID, 128'(1), "bp_rsp_held");
    expect_sig(S_IDI_VALID, 128'(0), "bp_read_blocked");
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_sig(S_IDI_VALID, 128'(0), "bp_read_blocked_hold");
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    expect_sig(S_IDI_VALID, 128'(1), "bp_read_released");
    tick();
    expect_sig(S_RD_INFLIGHT, 128'(1), "bp_second_inflight");
    tick();
    pulse_rvalid(32'($urandom));
    expect_sig(S_RSP_TAG, 128'(2), "bp_second_tag");
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Mixed ordering: write behind a read goes out while the read is in flight.
    bus.idi_ready = 1'b0;
    set_req(1'b0, 64'h400, '0, 4'd5);
    tick();
    set_req(1'b1, 64'h404, 32'hCAFE, 4'd6);
    tick();
    bus.req_valid = 1'b0;
    expect_sig(S_COUNT, 128'(2), "mix_count");
    expect_sig(S_IDI_VALID, 128'(1), "mix_read_head");
    bus.idi_ready = 1'b1;
    tick();
    expect_sig(S_RD_INFLIGHT, 128'(1), "mix_inflight");
    expect_sig(S_IDI_VALID, 128'(1), "mix_write_not_blocked");
    tick();
    expect_sig(S_COUNT, 128'(0), "mix_drained");
    tick();
    pulse_rvalid(32'($urandom));
    expect_sig(S_RSP_TAG, 128'(5), "mix_rsp_tag");
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Spurious completion is sticky.
    pulse_rvalid(32'($urandom));
    expect_sig(S_ERR, 128'(1), "spur_set");
    tick();
    tick();
    expect_sig(S_ERR, 128'(1), "spur_sticky");

    // Reset with a read in flight and two writes queued.
    set_req(1'b0, 64'h500, '0, 4'd7);
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.idi_ready = 1'b0;
    set_req(1'b1, 64'h504, 32'd1, 4'd8);
    tick();
    set_req(1'b1, 64'h508, 32'd2, 4'd9);
    tick();
    bus.req_valid = 1'b0;
    expect_sig(S_COUNT, 128'(2), "prerst_count");
    expect_sig(S_RD_INFLIGHT, 128'(1), "prerst_inflight");
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    expect_reset_state();
    tick();
    pulse_rvalid(32'($urandom));
    expect_sig(S_ERR, 128'(1), "late_rvalid_err");

    // Randomized traffic; the bridge returns each read 1..N cycles later.
    reads_returned = reads_dispatched;
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid    = ($urandom_range(0, 1) == 1);
      bus.req_is_write = ($urandom_range(0, 1) == 1);
      bus.req_addr     = {$urandom, $urandom};
      bus.req_wdata    = $urandom;
      bus.req_tag      = TAG_W'($urandom_range(0, 15));
      bus.idi_ready    = ($urandom_range(0, 3) != 0);
      bus.rsp_ready    = ($urandom_range(0, 1) == 1);
      if (reads_dispatched > reads_returned && $urandom_range(0, 2) == 0) begin
        bus.idi_rvalid = 1'b1;
        bus.idi_rdata  = $urandom;
        reads_returned++;
      end else begin
        bus.idi_rvalid = 1'b0;
      end
      tick();
    end

    // Drain everything still queued or outstanding.
    bus.req_valid = 1'b0;
    bus.idi_ready = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (reads_dispatched > reads_returned) begin
        bus.idi_rvalid = 1'b1;
        bus.idi_rdata  = $urandom;
        reads_returned++;
      end else begin
        bus.idi_rvalid = 1'b0;
      end
      tick();
    end
    bus.idi_rvalid = 1'b0;
    tick();
    expect_sig(S_EXPQ, 128'(0), "end_requests_dispatched");
    expect_sig(S_RSPQ, 128'(0), "end_responses_delivered");
    expect_sig(S_COUNT, 128'(0), "end_count");
    expect_sig(S_ERR, 128'(1), "end_err_sticky");
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
